// File: rtl/clock_replacement_unit_if.sv
// Hit/invalidate/victim-request bundle for the clock replacement unit.
// The master drives events and victim handshakes; the slave (the unit) answers.
interface clock_replacement_unit_if #(
  parameter int NUM_SETS      = 16,
  parameter int ASSOCIATIVITY = 4
);
  localparam int SW = $clog2(NUM_SETS);

  logic                     i_access_valid;
  logic [SW-1:0]            i_access_set;
  logic [ASSOCIATIVITY-1:0] i_access_way;
  logic                     i_inval_valid;
  logic [SW-1:0]            i_inval_set;
  logic [ASSOCIATIVITY-1:0] i_inval_way;
  logic                     i_victim_req_valid;
  logic [SW-1:0]            i_victim_req_set;
  logic                     o_victim_req_ready;
  logic                     o_victim_valid;
  logic [ASSOCIATIVITY-1:0] o_victim_mask;
  logic                     i_victim_ack;

  modport master (
    output i_access_valid, i_access_set, i_access_way,
    output i_inval_valid, i_inval_set, i_inval_way,
    output i_victim_req_valid, i_victim_req_set, i_victim_ack,
    input  o_victim_req_ready, o_victim_valid, o_victim_mask
  );

  modport slave (
    input  i_access_valid, i_access_set, i_access_way,
    input  i_inval_valid, i_inval_set, i_inval_way,
    input  i_victim_req_valid, i_victim_req_set, i_victim_ack,
    output o_victim_req_ready, o_victim_valid, o_victim_mask
  );
endinterface

// File: rtl/clock_replacement_unit.sv
// Per-set clock (second-chance) victim selection; victim valid 1 cycle after accept, held until ack.
// Requests stall only while a victim is pending; hits and invalidates are never back-pressured.
module clock_replacement_unit #(
  parameter int NUM_SETS      = 16,
  parameter int ASSOCIATIVITY = 4,
  parameter bit INVALID_FIRST = 1'b1
) (
  input logic                     i_clk,
  input logic                     i_rst_n,
  clock_replacement_unit_if.slave bus
);
  localparam int SW = $clog2(NUM_SETS);
  localparam int AW = ASSOCIATIVITY;
  localparam int IW = (AW > 1) ? $clog2(AW) : 1;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] RESULT = 1'b1;

  logic [0:0]    state_q;
  logic [AW-1:0] hand_q  [NUM_SETS];
  logic [AW-1:0] use_q   [NUM_SETS];
  logic [AW-1:0] valid_q [NUM_SETS];
  logic [AW-1:0] use_d   [NUM_SETS];
  logic [AW-1:0] valid_d [NUM_SETS];
  logic [AW-1:0] victim_q;
  logic [AW-1:0] sweep_q;
  logic [SW-1:0] set_q;

  logic          accept;
  logic          commit;
  logic          access_ok;
  logic          inval_ok;
  logic [AW-1:0] sel_use;
  logic [AW-1:0] sel_valid;
  logic [AW-1:0] sel_hand;
  logic [AW-1:0] sel_victim;
  logic [AW-1:0] sel_sweep;
  logic [IW-1:0] hand_idx;
  logic [IW-1:0] scan_idx;
  int            scan_pos;
  logic          inv_pick;
  logic          found;

  function automatic logic is_onehot(input logic [AW-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  assign accept    = (state_q == IDLE) && bus.i_victim_req_valid;
  assign commit    = (state_q == RESULT) && bus.i_victim_ack;
  assign access_ok = bus.i_access_valid && is_onehot(bus.i_access_way);
  assign inval_ok  = bus.i_inval_valid && is_onehot(bus.i_inval_way);

  assign bus.o_victim_req_ready = (state_q == IDLE);
  assign bus.o_victim_valid     = (state_q == RESULT);
  assign bus.o_victim_mask      = victim_q;

  // Later assignments win: ack commit, then hit, then invalidate.
  always_comb begin
    for (int s = 0; s < NUM_SETS; s++) begin
      use_d[s]   = use_q[s];
      valid_d[s] = valid_q[s];
      if (commit && (set_q == SW'(s))) begin
        use_d[s]   = (use_d[s] & ~sweep_q) | victim_q;
        valid_d[s] = valid_d[s] | victim_q;
      end
      if (access_ok && (bus.i_access_set == SW'(s)))
        use_d[s] = use_d[s] | (bus.i_access_way & valid_q[s]);
      if (inval_ok && (bus.i_inval_set == SW'(s))) begin
        use_d[s]   = use_d[s] & ~bus.i_inval_way;
        valid_d[s] = valid_d[s] & ~bus.i_inval_way;
      end
    end
  end

  // Selection sees the same-edge updates; the hand cannot move on an accept edge.
  assign sel_use   = use_d[bus.i_victim_req_set];
  assign sel_valid = valid_d[bus.i_victim_req_set];
  assign sel_hand  = hand_q[bus.i_victim_req_set];

  always_comb begin
    hand_idx = '0;
    for (int w = 0; w < AW; w++)
      if (sel_hand[w]) hand_idx = IW'(w);
  end

  always_comb begin
    inv_pick   = INVALID_FIRST && !(&sel_valid);
    found      = 1'b0;
    sel_victim = '0;
    sel_sweep  = '0;
    scan_pos   = 0;
    scan_idx   = '0;
    for (int i = 0; i < AW; i++) begin
      scan_pos = int'(hand_idx) + i;
      if (scan_pos >= AW) scan_pos = scan_pos - AW;
      scan_idx = IW'(scan_pos);
      if (!found) begin
        if (inv_pick ? !sel_valid[scan_idx] : !sel_use[scan_idx]) begin
          found                = 1'b1;
          sel_victim[scan_idx] = 1'b1;
        end else if (!inv_pick) begin
          sel_sweep[scan_idx] = 1'b1;
        end
      end
    end
    if (!found) begin
      sel_victim = sel_hand;
      sel_sweep  = ~sel_hand;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      victim_q <= '0;
      sweep_q  <= '0;
      set_q    <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        hand_q[s]  <= AW'(1);
        use_q[s]   <= '0;
        valid_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < NUM_SETS; s++) begin
        use_q[s]   <= use_d[s];
        valid_q[s] <= valid_d[s];
        if (commit && (set_q == SW'(s)))
          hand_q[s] <= {victim_q[AW-2:0], victim_q[AW-1]};
      end
      if (accept) begin
        state_q  <= RESULT;
        victim_q <= sel_victim;
        sweep_q  <= sel_sweep;
        set_q    <= bus.i_victim_req_set;
      end else if (commit) begin
        state_q  <= IDLE;
        victim_q <= '0;
        sweep_q  <= '0;
      end
    end
  end
endmodule

// File: tb/tb_clock_replacement_unit.sv
// Randomized and directed bench for two units (invalid-first and pure clock) sharing one stimulus.
// Victims are queued by a reference model at acceptance and compared by a negedge monitor.
module tb_clock_replacement_unit;
  localparam int NS = 16;
  localparam int A  = 4;
  localparam int SW = $clog2(NS);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          access_valid, inval_valid, req_valid, ack;
  logic [SW-1:0] access_set, inval_set, req_set;
  logic [A-1:0]  access_way, inval_way;

  int vectors = 0;
  int errors  = 0;
  bit mon_en  = 1'b0;

  always #5 clk = ~clk;

  clock_replacement_unit_if #(.NUM_SETS(NS), .ASSOCIATIVITY(A)) bus_a ();
  clock_replacement_unit_if #(.NUM_SETS(NS), .ASSOCIATIVITY(A)) bus_b ();

  assign bus_a.i_access_valid = access_valid;      assign bus_b.i_access_valid = access_valid;
  assign bus_a.i_access_set = access_set;          assign bus_b.i_access_set = access_set;
  assign bus_a.i_access_way = access_way;          assign bus_b.i_access_way = access_way;
  assign bus_a.i_inval_valid = inval_valid;        assign bus_b.i_inval_valid = inval_valid;
  assign bus_a.i_inval_set = inval_set;            assign bus_b.i_inval_set = inval_set;
  assign bus_a.i_inval_way = inval_way;            assign bus_b.i_inval_way = inval_way;
  assign bus_a.i_victim_req_valid = req_valid;     assign bus_b.i_victim_req_valid = req_valid;
  assign bus_a.i_victim_req_set = req_set;         assign bus_b.i_victim_req_set = req_set;
  assign bus_a.i_victim_ack = ack;                 assign bus_b.i_victim_ack = ack;

  clock_replacement_unit #(.NUM_SETS(NS), .ASSOCIATIVITY(A), .INVALID_FIRST(1'b1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus_a));
  clock_replacement_unit #(.NUM_SETS(NS), .ASSOCIATIVITY(A), .INVALID_FIRST(1'b0)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus_b));

  // Reference model: index 0 is invalid-first, index 1 is pure clock.
  logic [A-1:0] m_use [2][NS];
  logic [A-1:0] m_val [2][NS];
  int           m_hand[2][NS];
  bit           m_busy[2];
  logic [A-1:0] m_vic [2];
  logic [A-1:0] m_swp [2];
  int           m_set [2];
  logic [A-1:0] exp_q [2][$];
  bit           hit_ok, do_acc, do_com;
  logic [A-1:0] p_vic, p_swp;

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d @%0t: got %h, expected %h", name, k, $time, act, exp);
    end
  endtask

  function automatic void pick(input int k, input int s, output logic [A-1:0] vic, output logic [A-1:0] swp);
    int  h   = m_hand[k][s];
    int  v   = -1;
    bit  inv = (k == 0) && (m_val[k][s] != '1);
    for (int i = 0; i < A && v < 0; i++) begin
      int w = (h + i) % A;
      if (inv ? !m_val[k][s][w] : !m_use[k][s][w]) v = w;
    end
    vic = '0;
    swp = '0;
    if (v < 0) begin
      vic[h] = 1'b1;
      swp    = ~vic;
    end else begin
      vic[v] = 1'b1;
      if (!inv)
        for (int i = 0; i < A; i++) begin
          int w = (h + i) % A;
          if (w == v) break;
          swp[w] = 1'b1;
        end
    end
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        for (int s = 0; s < NS; s++) begin
          m_use[k][s] = '0; m_val[k][s] = '0; m_hand[k][s] = 0;
        end
        m_busy[k] = 1'b0;
        exp_q[k].delete();
      end else begin
        hit_ok = access_valid && ($countones(access_way) == 1) && ((m_val[k][access_set] & access_way) != '0);
        do_acc = !m_busy[k] && req_valid;
        do_com = m_busy[k] && ack;
        if (do_com) begin
          m_use[k][m_set[k]] = (m_use[k][m_set[k]] & ~m_swp[k]) | m_vic[k];
          m_val[k][m_set[k]] = m_val[k][m_set[k]] | m_vic[k];
          for (int w = 0; w < A; w++)
            if (m_vic[k][w]) m_hand[k][m_set[k]] = (w + 1) % A;
          m_busy[k] = 1'b0;
          void'(exp_q[k].pop_front());
        end
        if (hit_ok) m_use[k][access_set] = m_use[k][access_set] | access_way;
        if (inval_valid && ($countones(inval_way) == 1)) begin
          m_use[k][inval_set] = m_use[k][inval_set] & ~inval_way;
          m_val[k][inval_set] = m_val[k][inval_set] & ~inval_way;
        end
        if (do_acc) begin
          pick(k, int'(req_set), p_vic, p_swp);
          m_vic[k]  = p_vic;
          m_swp[k]  = p_swp;
          m_set[k]  = int'(req_set);
          m_busy[k] = 1'b1;
          exp_q[k].push_back(p_vic);
        end
      end
    end
  end

  // Monitor: handshake outputs, victim mask against the queue head, and per-set state.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 2; k++) begin
        logic         rdy, vld;
        logic [A-1:0] msk, eh;
        rdy = (k == 0) ? bus_a.o_victim_req_ready : bus_b.o_victim_req_ready;
        vld = (k == 0) ? bus_a.o_victim_valid : bus_b.o_victim_valid;
        msk = (k == 0) ? bus_a.o_victim_mask : bus_b.o_victim_mask;
        check("ready", k, 32'(rdy), 32'(!m_busy[k]));
        check("valid", k, 32'(vld), 32'(m_busy[k]));
        if (vld) begin
          check("queue_nonempty", k, 32'(exp_q[k].size() > 0), 32'd1);
          if (exp_q[k].size() > 0) check("victim_mask", k, 32'(msk), 32'(exp_q[k][0]));
        end
        for (int s = 0; s < NS; s++) begin
          eh = '0;
          eh[m_hand[k][s]] = 1'b1;
          check("set_use", k, 32'((k == 0) ? dut_a.use_q[s] : dut_b.use_q[s]), 32'(m_use[k][s]));
          check("set_valid", k, 32'((k == 0) ? dut_a.valid_q[s] : dut_b.valid_q[s]), 32'(m_val[k][s]));
          check("set_hand", k, 32'((k == 0) ? dut_a.hand_q[s] : dut_b.hand_q[s]), 32'(eh));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    access_valid = 1'b0; inval_valid = 1'b0; req_valid = 1'b0; ack = 1'b0;
  endtask

  task automatic do_req(input int s);
    req_valid = 1'b1; req_set = SW'(s); tick();
  endtask

  task automatic do_ack();
    ack = 1'b1; tick();
  endtask

  task automatic do_access(input int s, input int w);
    access_valid = 1'b1; access_set = SW'(s); access_way = A'(1) << w; tick();
  endtask

  task automatic fill(input int s);
    repeat (A) begin do_req(s); do_ack(); end
  endtask

  // Leaves set s with valid=1111, use=1011, hand=way0.
  task automatic build_1011(input int s);
    fill(s);
    do_req(s); do_ack();
    do_access(s, 1); do_access(s, 2);
    do_req(s); do_ack();
    do_access(s, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    access_valid = 1'b0; inval_valid = 1'b0; req_valid = 1'b0; ack = 1'b0;
    access_set = '0; inval_set = '0; req_set = '0; access_way = '0; inval_way = '0;
    tick();
    mon_en = 1'b1;
    tick();
    check("rst_ready", 0, 32'(bus_a.o_victim_req_ready), 32'd1);
    check("rst_valid", 0, 32'(bus_a.o_victim_valid), 32'd0);
    check("rst_mask", 0, 32'(bus_a.o_victim_mask), 32'd0);
    rst_n = 1'b1;
    tick();

    do_req(2);
    check("s1_valid", 0, 32'(bus_a.o_victim_valid), 32'd1);
    check("s1_mask", 0, 32'(bus_a.o_victim_mask), 32'b0001);
    do_ack();
    check("s1_hand", 0, 32'(dut_a.hand_q[2]), 32'b0010);
    check("s1_vbits", 0, 32'(dut_a.valid_q[2]), 32'b0001);
    check("s1_use", 0, 32'(dut_a.use_q[2]), 32'b0001);

    build_1011(5);
    do_req(5);
    check("s2_mask", 0, 32'(bus_a.o_victim_mask), 32'b0100);
    do_ack();
    check("s2_use", 0, 32'(dut_a.use_q[5]), 32'b1100);
    check("s2_hand", 0, 32'(dut_a.hand_q[5]), 32'b1000);

    fill(7);
    do_req(7); do_ack();
    do_access(7, 1); do_access(7, 2); do_access(7, 3);
    do_req(7);
    check("s3_mask", 0, 32'(bus_a.o_victim_mask), 32'b0010);
    do_ack();
    check("s3_use", 0, 32'(dut_a.use_q[7]), 32'b0010);
    check("s3_hand", 0, 32'(dut_a.hand_q[7]), 32'b0100);

    build_1011(6);
    do_req(6);
    ack = 1'b1; access_valid = 1'b1; access_set = SW'(6); access_way = 4'b0010;
    tick();
    check("s4_use", 0, 32'(dut_a.use_q[6]), 32'b1110);

    fill(8);
    inval_valid = 1'b1; inval_set = SW'(8); inval_way = 4'b1000;
    tick();
    do_req(8);
    check("s5_mask_a", 0, 32'(bus_a.o_victim_mask), 32'b1000);
    check("s5_mask_b", 1, 32'(bus_b.o_victim_mask), 32'b1000);
    do_ack();
    check("s5_use_a", 0, 32'(dut_a.use_q[8]), 32'b1111);
    check("s5_use_b", 1, 32'(dut_b.use_q[8]), 32'b1000);
    check("s5_hand_b", 1, 32'(dut_b.hand_q[8]), 32'b0001);

    do_req(9);
    rst_n = 1'b0;
    access_valid = 1'b1; access_set = SW'(2); access_way = 4'b0001;
    tick();
    check("s6_valid", 0, 32'(bus_a.o_victim_valid), 32'd0);
    check("s6_ready", 0, 32'(bus_a.o_victim_req_ready), 32'd1);
    check("s6_use2", 0, 32'(dut_a.use_q[2]), 32'd0);
    check("s6_hand2", 0, 32'(dut_a.hand_q[2]), 32'b0001);
    rst_n = 1'b1;
    do_ack();
    check("s6_ack_valid", 0, 32'(bus_a.o_victim_valid), 32'd0);
    check("s6_ack_vbits", 0, 32'(dut_a.valid_q[9]), 32'd0);
    check("s6_ack_hand", 0, 32'(dut_a.hand_q[9]), 32'b0001);

    for (int n = 0; n < 2000; n++) begin
      access_valid = ($urandom_range(0, 1) == 1);
      access_set   = SW'($urandom_range(0, 3));
      access_way   = ($urandom_range(0, 7) == 0) ? A'($urandom) : A'(1) << $urandom_range(0, A - 1);
      inval_valid  = ($urandom_range(0, 3) == 0);
      inval_set    = SW'($urandom_range(0, 3));
      inval_way    = ($urandom_range(0, 7) == 0) ? A'($urandom) : A'(1) << $urandom_range(0, A - 1);
      req_valid    = ($urandom_range(0, 1) == 1);
      req_set      = SW'($urandom_range(0, 3));
      ack          = ($urandom_range(0, 1) == 1);
      rst_n        = ($urandom_range(0, 199) != 0);
      tick();
    end
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/clock_replacement_unit.md
CLOCK_REPLACEMENT_UNIT -- requirements
Module: clock_replacement_unit

Parameters
REQ-001 The block SHALL have parameter NUM_SETS, default 16: number of cache sets tracked, power of two, at least 2.
REQ-002 The block SHALL have parameter ASSOCIATIVITY, default 4: ways per set, at least 2.
REQ-003 The block SHALL have parameter INVALID_FIRST, default 1: when 1, invalid ways are chosen before the clock sweep; when 0, pure clock policy.
REQ-004 SW SHALL be used as shorthand for $clog2(NUM_SETS) in the widths below.

Interface
REQ-005 The block SHALL have port i_clk  input  1: single clock; all state changes on the rising edge.
REQ-006 The block SHALL have port i_rst_n  input  1: reset, synchronous, active-low.
REQ-007 The block SHALL have port i_access_valid  input  1: cache hit, sets the use bit.
REQ-008 The block SHALL have port i_access_set  input  SW: set index of the hit.
REQ-009 The block SHALL have port i_access_way  input  ASSOCIATIVITY: one-hot way that hit.
REQ-010 The block SHALL have port i_inval_valid  input  1: invalidate request.
REQ-011 The block SHALL have port i_inval_set  input  SW: set index to invalidate.
REQ-012 The block SHALL have port i_inval_way  input  ASSOCIATIVITY: one-hot way to invalidate.
REQ-013 The block SHALL have port i_victim_req_valid  input  1: victim request.
REQ-014 The block SHALL have port i_victim_req_set  input  SW: set index of the victim request.
REQ-015 The block SHALL have port o_victim_req_ready  output  1: request accepted when valid and ready are both 1.
REQ-016 The block SHALL have port o_victim_valid  output  1: victim result present.
REQ-017 The block SHALL have port o_victim_mask  output  ASSOCIATIVITY: one-hot victim way.
REQ-018 The block SHALL have port i_victim_ack  input  1: victim consumed and the way filled; commits the state update.

Function
REQ-019 Each set SHALL hold a one-hot hand pointer, a use vector and a valid vector.
REQ-020 The FSM SHALL have two states: IDLE and RESULT.
REQ-021 o_victim_req_ready SHALL be 1 exactly in IDLE.
REQ-022 On an accepted request, the FSM SHALL go IDLE->RESULT and the victim mask and set index SHALL be registered; o_victim_valid SHALL be 1 on the next cycle (latency 1).
REQ-023 In RESULT, o_victim_valid and o_victim_mask SHALL be held stable until i_victim_ack; on ack the FSM SHALL go RESULT->IDLE, giving a maximum of one victim per 2 cycles.
REQ-024 i_victim_ack SHALL be ignored in IDLE, and i_victim_req_valid SHALL be ignored in RESULT.
REQ-025 Victim selection, invalid-first: if INVALID_FIRST=1 and any valid bit is 0, the victim SHALL be the first invalid way scanning circularly from the hand, inclusive; no use bits are marked for clearing.
REQ-026 Victim selection, clock sweep: otherwise the victim SHALL be the first way with use=0 scanning circularly from the hand, inclusive.
REQ-027 Victim selection, all used: if every use bit is 1, the victim SHALL be the hand way.
REQ-028 Swept ways SHALL be the ways from the hand, inclusive, up to the victim, exclusive, circularly; in the all-ones case this is every way except the victim.
REQ-029 Selection SHALL use the set state as it stands at the acceptance edge, including updates applied on that same edge.
REQ-030 On ack, in the registered set: the use bits of swept ways SHALL be cleared, victim use=1, victim valid=1, and the hand SHALL move to victim+1 mod ASSOCIATIVITY.
REQ-031 Access SHALL set use=1 for the given way in the given set; it has no effect if that way is invalid.
REQ-032 Invalidate SHALL clear valid and use for the given way in the given set.
REQ-033 Same-cycle priority per way bit SHALL be invalidate > access > ack commit; the hand SHALL be changed only by ack.
REQ-034 A hit on a swept way in the ack cycle SHALL leave its use bit at 1.
REQ-035 Events to different sets in the same cycle SHALL all apply.
REQ-036 Access and invalidate SHALL be accepted in every state with no backpressure.
REQ-037 A way mask that is not one-hot SHALL be ignored for that event.
REQ-038 A victim already registered SHALL NOT be recomputed after a later invalidate or access; the committed victim is the registered one.
REQ-039 A set index at or above NUM_SETS cannot occur, because NUM_SETS is a power of two.

Reset
REQ-040 While i_rst_n=0 at a clock edge: FSM=IDLE, o_victim_valid=0, o_victim_mask=0, o_victim_req_ready=1 after the edge.
REQ-041 While i_rst_n=0 at a clock edge: every set SHALL get hand=way0, use=0, valid=0.
REQ-042 Reset in RESULT SHALL drop the pending victim without committing it.
REQ-043 All inputs SHALL be ignored during reset.

Verification
REQ-044 The bench SHALL cover, with defaults (INVALID_FIRST=1) and ASSOCIATIVITY=4, at least these scenarios:
- Reset, request set 2 -> o_victim_valid=1 next cycle, mask 0001; ack -> set 2 hand=0010, valid=0001, use=0001.
- Set 5 all valid, use=1011, hand=0001, request -> mask 0100; ack -> use=1100, hand=1000.
- Set 5 all valid, use=1111, hand=0010 -> mask 0010; ack -> use=0010, hand=0100.
- Setup as the second scenario, access way 1 of set 5 in the ack cycle -> use=1110 after commit.
- Full set with use=1111, invalidate way 3, then request -> mask 1000; second request with INVALID_FIRST=0 and the same state pattern -> clock-sweep result instead.
- Reset asserted in RESULT -> o_victim_valid=0 and ready=1 next cycle; set state back to reset values; a later ack has no effect.
